// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings and helpers for the memory access unit.
`default_nettype none

package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } mau_state_t;

    // Reserved size maps to one byte; it is rejected before any access.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        case (sz)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mau_load_extend.sv
// mau_load_extend: zero/sign extension of the assembled load bytes.
`default_nettype none

module mau_load_extend
    import mau_pkg::*;
(
    input  logic [31:0] i_acc,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    always_comb begin
        o_result = i_acc;
        case (i_size)
            SZ_BYTE: o_result = {{24{i_signed & i_acc[7]}},  i_acc[7:0]};
            SZ_HALF: o_result = {{16{i_signed & i_acc[15]}}, i_acc[15:0]};
            default: o_result = i_acc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: big-endian byte-serial load/store initiator with range checks.
// Optional alignment checking enabled by defining MAU_ALIGN_CHECK_EN.
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    mau_state_t        r_state;
    mau_state_t        w_next;
    logic              r_write;
    logic              r_signed;
    logic              r_err;
    logic [1:0]        r_size;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_acc;

    logic [2:0]        w_req_n;
    logic [2:0]        w_cur_n;
    logic [32:0]       w_last_addr;
    logic              w_range_err;
    logic              w_align_err;
    logic              w_req_err;
    logic              w_accept;
    logic              w_last;
    logic [1:0]        w_byte_idx;
    logic [31:0]       w_ext;

    assign w_req_n     = size_to_bytes(req_size);
    assign w_cur_n     = size_to_bytes(r_size);
    assign w_last_addr = {1'b0, req_addr} + 33'(w_req_n) - 33'd1;
    assign w_range_err = (w_last_addr >> ADDR_W) != 33'd0;

`ifdef MAU_ALIGN_CHECK_EN
    assign w_align_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_align_err = 1'b0;
`endif

    assign w_req_err  = (req_size == 2'b11) || w_range_err || w_align_err;
    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_last     = (r_cnt == 2'(w_cur_n - 3'd1));
    // Big-endian: the first transferred byte is the most significant of the field.
    assign w_byte_idx = 2'(w_cur_n - 3'd1 - {1'b0, r_cnt});

    mau_load_extend u_extend (
        .i_acc    (r_acc),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_result (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = w_req_err ? ST_RESP : ST_XFER;
            ST_XFER: if (w_last)    w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= SZ_BYTE;
            r_cnt    <= 2'd0;
            r_base   <= '0;
            r_wdata  <= 32'd0;
            r_acc    <= 32'd0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_err    <= w_req_err;
            r_size   <= req_size;
            r_cnt    <= 2'd0;
            r_base   <= req_addr[ADDR_W-1:0];
            r_wdata  <= req_wdata;
            r_acc    <= 32'd0;
        end else if (r_state == ST_XFER) begin
            r_cnt <= r_cnt + 2'd1;
            if (!r_write) begin
                r_acc <= {r_acc[23:0], mem_rdata};
            end
        end
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'd0;
        case (r_state)
            ST_XFER: begin
                mem_read  = !r_write;
                mem_write = r_write;
                mem_addr  = r_base + ADDR_W'(r_cnt);
                mem_wdata = r_write ? 8'(r_wdata >> {w_byte_idx, 3'b000}) : 8'd0;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (!r_write && !r_err) ? w_ext : 32'd0;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte memory model for mem_access_unit.
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          t_acc;
        int          lat;
    } resp_t;

    resp_t       respq [$];
    logic [15:0] wq    [$];
    logic [7:0]  rq    [$];

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && mem_write) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: strobes and responses are compared against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write) check("rw_both", 32'd1, 32'd0);
            if (mem_write) begin
                if (wq.size() == 0) check("unexp_write", 32'd1, 32'd0);
                else begin
                    logic [15:0] w;
                    w = wq.pop_front();
                    check("wr_addr", {24'd0, mem_addr}, {24'd0, w[15:8]});
                    check("wr_data", {24'd0, mem_wdata}, {24'd0, w[7:0]});
                end
            end
            if (mem_read) begin
                if (rq.size() == 0) check("unexp_read", 32'd1, 32'd0);
                else begin
                    logic [7:0] a;
                    a = rq.pop_front();
                    check("rd_addr", {24'd0, mem_addr}, {24'd0, a});
                end
            end
            if (resp_valid) begin
                if (respq.size() == 0) check("unexp_resp", 32'd1, 32'd0);
                else begin
                    resp_t e;
                    e = respq.pop_front();
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_lat", 32'(cyc - e.t_acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; pushes expectations then drives one request.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd);
        int    n;
        int    guard;
        resp_t e;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        wait_ready();
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                if (wr) wq.push_back({addr[7:0] + 8'(i), 8'(wd >> (8 * (n - 1 - i)))});
                else    rq.push_back(addr[7:0] + 8'(i));
            end
        end
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.t_acc = cyc + 1;
        e.lat   = exp_err ? 0 : n;
        respq.push_back(e);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_size   = 2'(($urandom));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_signed = 1'($urandom);
        req_write  = 1'($urandom);
        guard = 0;
        while (respq.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (respq.size() != 0) begin
            check("resp_timeout", 32'd0, 32'd1);
            respq.delete();
        end
        if (wq.size() != 0 || rq.size() != 0) begin
            check("missing_strobes", 32'(wq.size() + rq.size()), 32'd0);
            wq.delete();
            rq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h02] = 8'h11; mem[8'h03] = 8'h22; mem[8'h04] = 8'h33; mem[8'h05] = 8'h7F;
        mem[8'h20] = 8'h80; mem[8'h21] = 8'h01;
        mem[8'hFE] = 8'hAB; mem[8'hFF] = 8'hCD;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678);
        issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 32'hFFFF8001);
        issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00008001);
        issue(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 1'b0, 32'h0000007F);
        issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, 32'hFFFFFF80);
`ifdef MAU_ALIGN_CHECK_EN
        issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h31, 32'h1234, 1'b1, 32'h0);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b0, 32'h1122337F);
        issue(1'b1, 2'b01, 1'b0, 32'h31, 32'h1234, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 1'b0, 32'h00001234);
`endif
        issue(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'hFE, 32'hFFFFFFFF, 1'b1, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'hFE, 32'h0, 1'b0, 32'h0000ABCD);
        issue(1'b1, 2'b01, 1'b0, 32'h30, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000005A, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 32'hFFFFBE5A);

        // Reset during the second write cycle of a word store.
        wait_ready();
        wq.push_back({8'h40, 8'hAA});
        wq.push_back({8'h41, 8'hBB});
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("mid_xfer_write", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_async_ready", {31'd0, req_ready}, 32'd1);
        wq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_byte0", {24'd0, mem[8'h40]}, 32'h000000AA);
        check("post_rst_byte1", {24'd0, mem[8'h41]}, 32'h00000000);

        issue(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 1'b0, 32'h0000007F);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the CPU's memory stage and the byte-organised data memory. Accepts one load or store request (byte, halfword, word) from the pipeline, sequences it as big-endian single-byte accesses on the memory's read/write port, and returns zero- or sign-extended load data with an error flag. Enforces alignment and range checks before touching memory.

## Interface
- ADDR_W, 8, memory byte-address width (256 entries)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when both high
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  request rejected, no memory access made
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  combinational read byte for mem_addr

## Operation
- States: IDLE, XFER, RESP. req_ready = (state==IDLE).
- IDLE, req_valid: latch request; N = 1/2/4 bytes. Error if size==11, or req_addr+N-1 exceeds 2^ADDR_W-1 (upper bits nonzero), or misalignment (see Configuration). Error -> RESP with resp_err=1, no mem strobes. Else -> XFER, cnt=0.
- XFER: mem_addr = base+cnt; store drives mem_write=1, mem_wdata = byte cnt of the N-byte field, MSB first (word: cnt0=[31:24]; half: cnt0=[15:8], cnt1=[7:0]; byte: [7:0]). Load drives mem_read=1, acc <= {acc[23:0], mem_rdata} at clock edge. cnt==N-1 -> RESP.
- RESP: resp_valid=1 one cycle; loads: resp_rdata = acc low 8N bits, extended by req_signed from bit 8N-1; stores: 0. -> IDLE.
- No response back-pressure; consumer must take the pulse.
- mem_read and mem_write never both high; both low outside XFER.

## Timing
- Accept edge T; XFER cycles T+1..T+N; resp_valid in cycle T+N+1; next request accepted at earliest edge ending cycle T+N+2 (req_ready high again).
- Error requests: resp_valid in cycle T+1.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, acc 0.
- Reset asserted mid-XFER: strobes drop immediately (async), transaction abandoned, no response; bytes already written stay written.
- req_valid while busy ignored; request fields sampled only on acceptance edge.

## Configuration
- MAU_ALIGN_CHECK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 -> resp_err, no access.
- Undefined: misaligned accesses performed byte-serially at base..base+N-1 as normal; only size/range errors remain.

## Structure
- Shared package mau_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state enum, byte-count function size->N.
- One sub-module mau_load_extend: combinational acc+size+signed -> 32-bit result.

## Test plan
- Store word 0x12345678 at 0x10 -> 4 write cycles, addr 0x10..0x13 with bytes 12,34,56,78; resp_valid at T+5, resp_err 0.
- Load half signed at 0x20 holding bytes 0x80,0x01 -> 2 read cycles, resp_rdata 0xFFFF8001; unsigned -> 0x00008001.
- Load byte signed at 0x05 holding 0x7F -> resp_rdata 0x0000007F at T+2.
- Word load at 0x02: with MAU_ALIGN_CHECK_EN resp_err=1 at T+1, no strobes; without it, reads 0x02..0x05 concatenated.
- Word access at 0xFE or req_size 11 -> resp_err=1, mem_read/mem_write never asserted.
- rst_n low during second write cycle of a word store -> strobes drop at once, no resp_valid, req_ready 1 after release.
